// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//   Shares one 8-bit ALU between two requesters (0: core, 1: IO/DMA).
//   Each accepted request is sequenced in four steps. The block drives the
//   operands and opcode with the enable low so the ALU can settle. It then
//   raises the enable and samples the ALU result bus. Finally it holds a 16-bit
//   result on a valid/ready response until the owning requester consumes it.
//
//   Optional feature (macro WIDE_MUL_EN):
//     When defined, opcode 0x7 takes a second ALU pass with opcode 0x08 to
//     fetch the high product byte, so resp_data carries the full 16-bit a*b.
//     When undefined, 0x7 returns the low byte only.
//
// Parameters
//   FIXED_PRIO  0: round-robin on simultaneous requests; 1: requester 0 wins
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req_valid    [1:0]  per-requester operation pending
//   req_ready    [1:0]  per-requester accept strobe (one-hot or zero)
//   req_op       [7:0]  {op1, op0} 4-bit opcodes
//   req_a/req_b  [15:0] {x1, x0} 8-bit operands
//   resp_valid   [1:0]  one-hot response present for requester i
//   resp_ready   [1:0]  requester i consumes the response
//   resp_data    [15:0] result
//   resp_err     rejected opcode (0xE/0xF), qualified by resp_valid
//   alu_opcode/alu_a/alu_b/alu_en  drive the shared ALU
//   alu_data     ALU result bus (valid only while alu_en is high)
//   busy         controller not idle
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic [7:0]  alu_opcode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_en,
    input  logic [7:0]  alu_data,
    output logic        busy
);

`ifdef WIDE_MUL_EN
    localparam logic [3:0] OP_MUL    = 4'h7;
    localparam logic [7:0] OP_MUL_HI = 8'h08;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_CAPT     = 3'd2,
`ifdef WIDE_MUL_EN
        S_HI_ISSUE = 3'd3,
        S_HI_CAPT  = 3'd4,
`endif
        S_RESP     = 3'd5
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

    state_t      state_q, state_nx;
    req_t        lat_q;       // operands captured at grant
    req_t        req_sel;     // operands of the requester being granted
    logic        gnt_q;       // owner of the in-flight operation
    logic        last_gnt_q;  // last requester granted (round-robin history)
    logic [15:0] data_q;
    logic        err_q;

    logic        gnt_idx;
    logic        grant_fire;
    logic        sel_rej;

    // ------------------------------------------------------------------
    // Arbitration: a lone request wins outright; a tie goes to requester 0
    // under fixed priority, otherwise to whoever was not granted last.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_idx = 1'b0;
        case (req_valid)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
            default: gnt_idx = 1'b0;
        endcase
    end

    always_comb begin
        req_sel.op = gnt_idx ? req_op[7:4]  : req_op[3:0];
        req_sel.a  = gnt_idx ? req_a[15:8]  : req_a[7:0];
        req_sel.b  = gnt_idx ? req_b[15:8]  : req_b[7:0];
    end

    // rst gates the accept strobe so nothing is acknowledged while the
    // controller is being cleared.
    assign grant_fire = (state_q == S_IDLE) && (|req_valid) && !rst;
    // 0xE and 0xF are rejected without touching the ALU.
    assign sel_rej    = &req_sel.op[3:1];

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_data  = 16'h0000;
        resp_err   = 1'b0;
        alu_opcode = 8'h00;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_en     = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (grant_fire) begin
                    req_ready = gnt_idx ? 2'b10 : 2'b01;
                    state_nx  = sel_rej ? S_RESP : S_ISSUE;
                end
            end

            // Operands presented with enable low so the ALU settles first.
            S_ISSUE: begin
                alu_opcode = {4'h0, lat_q.op};
                alu_a      = lat_q.a;
                alu_b      = lat_q.b;
                state_nx   = S_CAPT;
            end

            S_CAPT: begin
                alu_opcode = {4'h0, lat_q.op};
                alu_a      = lat_q.a;
                alu_b      = lat_q.b;
                alu_en     = 1'b1;
`ifdef WIDE_MUL_EN
                state_nx   = (lat_q.op == OP_MUL) ? S_HI_ISSUE : S_RESP;
`else
                state_nx   = S_RESP;
`endif
            end

`ifdef WIDE_MUL_EN
            // Second pass for the high product byte; same operands.
            S_HI_ISSUE: begin
                alu_opcode = OP_MUL_HI;
                alu_a      = lat_q.a;
                alu_b      = lat_q.b;
                state_nx   = S_HI_CAPT;
            end

            S_HI_CAPT: begin
                alu_opcode = OP_MUL_HI;
                alu_a      = lat_q.a;
                alu_b      = lat_q.b;
                alu_en     = 1'b1;
                state_nx   = S_RESP;
            end
`endif

            // Response held until its owner takes it; the other ready bit is
            // ignored and no new grant happens here.
            S_RESP: begin
                resp_valid = gnt_q ? 2'b10 : 2'b01;
                resp_data  = data_q;
                resp_err   = err_q;
                if (resp_ready[gnt_q]) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latch and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;    // so requester 0 wins the first tie
            data_q     <= 16'h0000;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_nx;

            if (grant_fire) begin
                lat_q      <= req_sel;
                gnt_q      <= gnt_idx;
                last_gnt_q <= gnt_idx;
                data_q     <= 16'h0000;
                err_q      <= sel_rej;
            end

            if (state_q == S_CAPT) begin
                data_q <= {8'h00, alu_data};
            end

`ifdef WIDE_MUL_EN
            if (state_q == S_HI_CAPT) begin
                data_q[15:8] <= alu_data;
            end
`endif
        end
    end

endmodule
